// File: rtl/simmem_wresp_delay_tracker.sv
// simmem_wresp_delay_tracker: counts down per-write delays and grants response release per ID, oldest first.
module simmem_wresp_delay_tracker #(
  parameter int NumSlots   = 8,
  parameter int IDWidth    = 4,
  parameter int DelayWidth = 6,
  parameter int NumIds     = 2**IDWidth
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            waddr_valid_i,
  output logic                            waddr_ready_o,
  input  logic [IDWidth-1:0]              waddr_id_i,
  input  logic [DelayWidth-1:0]           delay_i,
  output logic [NumIds-1:0]               release_en_o,
  input  logic                            released_valid_i,
  input  logic [IDWidth-1:0]              released_id_i,
  output logic [$clog2(NumSlots+1)-1:0]   occupancy_o
);
  localparam int OccW = $clog2(NumSlots+1);
  logic [NumSlots-1:0]   valid_q, valid_d;
  logic [IDWidth-1:0]    id_q [NumSlots];
  logic [IDWidth-1:0]    id_d [NumSlots];
  logic [DelayWidth-1:0] cnt_q [NumSlots];
  logic [DelayWidth-1:0] cnt_d [NumSlots];
  // age_q[i][j] set: slot j was allocated before slot i
  logic [NumSlots-1:0]   age_q [NumSlots];
  logic [NumSlots-1:0]   age_d [NumSlots];
  logic [NumSlots-1:0]   elig, free_oh, alloc_oh;
  logic                  acc;
  assign waddr_ready_o = ~&valid_q;
  assign acc           = waddr_valid_i && waddr_ready_o;
  assign alloc_oh      = acc ? (~valid_q & (valid_q + NumSlots'(1))) : '0;
  always_comb begin
    elig         = '0;
    free_oh      = '0;
    release_en_o = '0;
    occupancy_o  = '0;
    for (int i = 0; i < NumSlots; i++) begin
      elig[i] = valid_q[i] && cnt_q[i] == '0;
      for (int j = 0; j < NumSlots; j++)
        if (valid_q[j] && age_q[i][j] && id_q[j] == id_q[i]) elig[i] = 1'b0;
      if (elig[i]) release_en_o[id_q[i]] = 1'b1;
      free_oh[i]  = released_valid_i && elig[i] && id_q[i] == released_id_i;
      occupancy_o = occupancy_o + OccW'(valid_q[i]);
    end
  end
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      valid_d[i] = (valid_q[i] && !free_oh[i]) || alloc_oh[i];
      id_d[i]    = alloc_oh[i] ? waddr_id_i : id_q[i];
      cnt_d[i]   = alloc_oh[i] ? delay_i :
                   (valid_q[i] && cnt_q[i] != '0) ? cnt_q[i] - DelayWidth'(1) : cnt_q[i];
      age_d[i]   = alloc_oh[i] ? (valid_q & ~free_oh) :
                   free_oh[i]  ? '0 : (age_q[i] & ~free_oh & ~alloc_oh);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= id_d[i];
        cnt_q[i] <= cnt_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end
  // A release for an ID with no eligible entry is a protocol error; state is left untouched.
  a_release_granted: assert property (@(posedge clk_i) disable iff (rst_i)
    released_valid_i |-> release_en_o[released_id_i]);
endmodule
